pipe_skid_stage: RTL and testbench

Parametrised, elastic pipeline register that replaces fixed enable/clear stage registers with a valid/ready handshake and a two-entry skid buffer. It sits between any two pipeline stages (e.g. EX→MEM, MEM→WB) and carries an arbitrary-width payload. It sustains one transfer per cycle with a fully registered `in_ready_o`, supports a synchronous flush, and optionally reports stall and bubble statistics.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_sat_counter.sv | 33 +++
 rtl/pipe_skid_stage.sv | 137 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage.
package pipe_pkg;

    localparam int unsigned PIPE_DEF_WIDTH = 32;
    localparam int unsigned PIPE_DEF_CNT_W = 16;

    // Occupancy encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stage stall/bubble statistics.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already at the all-ones ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a two-entry skid buffer and a registered
// in_ready_o. Define PIPE_SKID_PERF_EN to add saturating stall/bubble counters.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never depends on ready, and once out_valid_o is raised it stays
// high with stable out_data_o until out_fire or flush_i.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_DEF_WIDTH,
    parameter int CNT_W = PIPE_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire;
    logic             out_fire;
    pipe_state_e      state_dbg;

    assign state_dbg = pipe_state_e'({skid_v_q, main_v_q});
    assign in_fire   = in_valid_i & in_ready_q;
    assign out_fire  = main_v_q & out_ready_i;

    // Occupancy transitions; payloads load only on the accepting events.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush_i) begin
            // Flush wins over a simultaneous in_fire; payloads are kept.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (state_dbg)
                EMPTY: begin
                    if (in_fire) begin
                        main_v_d = 1'b1;
                        main_d   = in_data_i;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_v_d = 1'b1;
                        skid_d   = in_data_i;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        skid_v_d = 1'b0;
                        main_d   = skid_q;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
        // Ready is precomputed from next occupancy so it leaves a flop.
        in_ready_d = ~skid_v_d;
    end

    // Stage registers; asynchronous reset drops any in-flight data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

`ifdef PIPE_SKID_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = main_v_q & ~out_ready_i;
    assign bubble_inc = ~main_v_q;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );
`endif

    param_ok_a: assert property (@(posedge clk) (WIDTH >= 1) && (CNT_W >= 1));

    legal_state_a: assert property (@(posedge clk) disable iff (!rst_n)
        state_dbg != pipe_state_e'(2'b10));

    hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (main_v_q && !out_ready_i && !flush_i) |=> (main_v_q && $stable(main_q)));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage; honours PIPE_SKID_PERF_EN.
module tb_pipe_skid_stage;

    localparam int W  = 32;
    localparam int CW = 4;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b0;
    logic         flush_i     = 1'b0;
    logic         in_valid_i  = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] in_data_i   = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] out_data_o;
`ifdef PIPE_SKID_PERF_EN
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] bubble_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", in_ready_o); end
        vectors++;
        if (out_data_o !== '0) begin miscompares++; $display("FAIL reset_data got %h exp 0", out_data_o); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got %b exp 0", out_valid_o); end
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (out_valid_o !== 1'b1 || out_data_o !== W'(i)) begin
                miscompares++;
                $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", i, out_valid_o, out_data_o, i);
            end
            vectors++;
            if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL stream_ready%0d got %b exp 1", i, in_ready_o); end
            if (i < 3) in_data_i = W'(i + 1);
            else       in_valid_i = 1'b0;
        end
        tick();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b exp 0", out_valid_o); end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hA;
        tick();
        vectors++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hA || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_first got v=%b d=%h r=%b exp v=1 d=a r=1", out_valid_o, out_data_o, in_ready_o);
        end
        in_data_i = 32'hB;
        tick();
        vectors++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hA || in_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full got v=%b d=%h r=%b exp v=1 d=a r=0", out_valid_o, out_data_o, in_ready_o);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        vectors++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hB || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drain got v=%b d=%h r=%b exp v=1 d=b r=1", out_valid_o, out_data_o, in_ready_o);
        end
        tick();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b exp 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h11;
        tick();
        in_data_i = 32'h22;
        tick();
        vectors++;
        if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_setup_full got r=%b exp 0", in_ready_o); end
        in_data_i = 32'hC;
        flush_i   = 1'b1;
        tick();
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full got v=%b r=%b exp v=0 r=1", out_valid_o, in_ready_o);
        end
        vectors++;
        if (out_data_o !== 32'h11) begin miscompares++; $display("FAIL flush_keeps_payload got %h exp 11", out_data_o); end
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_no_c cyc%0d got v=%b d=%h exp v=0", i, out_valid_o, out_data_o); end
        end
        // Flush with a simultaneous accept while holding one entry.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h33;
        tick();
        in_data_i = 32'hD;
        flush_i   = 1'b1;
        tick();
        vectors++;
        if (out_valid_o !== 1'b0 || out_data_o !== 32'h33 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_one got v=%b d=%h r=%b exp v=0 d=33 r=1", out_valid_o, out_data_o, in_ready_o);
        end
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h44;
        tick();
        in_data_i = 32'h55;
        tick();
        in_valid_i = 1'b0;
        vectors++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_setup got v=%b r=%b exp v=1 r=0", out_valid_o, in_ready_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_data_o !== '0) begin
            miscompares++;
            $display("FAIL arst_immediate got v=%b r=%b d=%h exp v=0 r=1 d=0", out_valid_o, in_ready_o, out_data_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL arst_release got %b exp 0", out_valid_o); end
    endtask

`ifdef PIPE_SKID_PERF_EN
    task automatic test_perf();
        rst_n       = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h77;
        #2;
        vectors++;
        if (stall_cnt_o !== '0 || bubble_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL perf_reset got s=%0d b=%0d exp 0 0", stall_cnt_o, bubble_cnt_o);
        end
        tick();
        rst_n = 1'b1;
        // First edge after release: stage empty (one bubble), entry accepted.
        tick();
        in_valid_i = 1'b0;
        repeat (20) tick();
        vectors++;
        if (stall_cnt_o !== 4'd15) begin miscompares++; $display("FAIL perf_stall_sat got %0d exp 15", stall_cnt_o); end
        vectors++;
        if (bubble_cnt_o !== 4'd1) begin miscompares++; $display("FAIL perf_bubble_hold got %0d exp 1", bubble_cnt_o); end
        out_ready_i = 1'b1;
        tick();
        repeat (3) tick();
        vectors++;
        if (bubble_cnt_o !== 4'd4 || stall_cnt_o !== 4'd15) begin
            miscompares++;
            $display("FAIL perf_bubble_idle got b=%0d s=%0d exp b=4 s=15", bubble_cnt_o, stall_cnt_o);
        end
    endtask
`endif

    // Reference: a FIFO of capacity two; ready means room for another entry.
    task automatic test_random(input int n);
        flush_i    = 1'b1;
        in_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            logic exp_ready, exp_valid, do_in, do_out, do_flush;
            logic [W-1:0] din;
            exp_ready = (exp_q.size() < 2);
            exp_valid = (exp_q.size() > 0);
            vectors++;
            if (in_ready_o !== exp_ready) begin miscompares++; $display("FAIL rnd_ready cyc%0d got %b exp %b", c, in_ready_o, exp_ready); end
            vectors++;
            if (out_valid_o !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cyc%0d got %b exp %b", c, out_valid_o, exp_valid); end
            if (exp_valid) begin
                vectors++;
                if (out_data_o !== exp_q[0]) begin miscompares++; $display("FAIL rnd_data cyc%0d got %h exp %h", c, out_data_o, exp_q[0]); end
            end
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = $urandom();
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 63) == 0);
            do_in    = in_valid_i && exp_ready;
            do_out   = exp_valid && out_ready_i;
            do_flush = flush_i;
            din      = in_data_i;
            tick();
            if (do_flush) begin
                exp_q.delete();
            end else begin
                if (do_out) void'(exp_q.pop_front());
                if (do_in) exp_q.push_back(din);
            end
        end
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef PIPE_SKID_PERF_EN
        test_perf();
`endif
        test_random(10000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
